// File: rtl/flash_op_seq.sv
// Flash operation sequencer: expands one software read/program/erase operation
// into per-word requests toward the flash memory-protection stage.
module flash_op_seq #(
    parameter int BankW = 1,
    parameter int PageW = 8,
    parameter int WordW = 8,
    parameter int CntW  = 12
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           op_start_i,
    input  logic [1:0]                     op_type_i,
    input  logic                           op_erase_sel_i,
    input  logic [BankW+PageW+WordW-1:0]   op_addr_i,
    input  logic [CntW-1:0]                op_num_words_i,
    input  logic                           prog_fifo_rvalid_i,
    output logic                           prog_fifo_rready_o,
    input  logic                           rd_fifo_wready_i,
    output logic                           req_o,
    output logic [BankW+PageW-1:0]         req_addr_o,
    output logic [WordW-1:0]               req_word_o,
    output logic [BankW-1:0]               req_bk_o,
    output logic                           addr_ovfl_o,
    output logic                           rd_o,
    output logic                           prog_o,
    output logic                           pg_erase_o,
    output logic                           bk_erase_o,
    input  logic                           rd_done_i,
    input  logic                           prog_done_i,
    input  logic                           erase_done_i,
    input  logic                           error_i,
    output logic                           op_busy_o,
    output logic                           op_done_o,
    output logic                           op_err_o
);

    localparam int AW = BankW + PageW + WordW;

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_e;
    typedef enum logic [1:0] {OP_RD, OP_PROG, OP_PG_ERASE, OP_BK_ERASE} kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q;
    logic [AW:0]     addr_q;        // MSB is the wrap-past-top flag
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] num_q;
    logic            err_q;

    logic gate_open;
    logic done_hit;
    logic load;
    logic advance;
    logic set_err;

    // Request gating and completion matching for the latched operation kind
    always_comb begin
        gate_open = 1'b1;
        done_hit  = 1'b0;
        unique case (kind_q)
            OP_RD:   begin gate_open = rd_fifo_wready_i;   done_hit = rd_done_i;    end
            OP_PROG: begin gate_open = prog_fifo_rvalid_i; done_hit = prog_done_i;  end
            default: begin gate_open = 1'b1;               done_hit = erase_done_i; end
        endcase
        // A done arriving while no request is presented is spurious and ignored
        done_hit = done_hit && (state_q == REQ) && gate_open;
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational
    // blocks use blocking assignments with a default first so no latch is inferred.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            kind_q  <= OP_RD;
            addr_q  <= '0;
            count_q <= '0;
            num_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                unique case (op_type_i)
                    2'd0:    kind_q <= OP_RD;
                    2'd1:    kind_q <= OP_PROG;
                    2'd2:    kind_q <= op_erase_sel_i ? OP_BK_ERASE : OP_PG_ERASE;
                    default: kind_q <= OP_RD;
                endcase
                addr_q  <= {1'b0, op_addr_i};
                count_q <= '0;
                num_q   <= op_num_words_i;
                err_q   <= (op_type_i == 2'd3);
            end else begin
                if (advance) begin
                    addr_q  <= addr_q + (AW+1)'(1);
                    count_q <= count_q + CntW'(1);
                end
                if (set_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        set_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op_start_i) begin
                    load    = 1'b1;
                    state_d = (op_type_i == 2'd3) ? DONE : REQ;
                end
            end
            REQ: begin
                if (done_hit) begin
                    if (error_i) begin
                        set_err = 1'b1;
                        state_d = DONE;
                    end else if (kind_q == OP_PG_ERASE || kind_q == OP_BK_ERASE) begin
                        state_d = DONE;
                    end else if (count_q == num_q) begin
                        state_d = DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP:     state_d = REQ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_o              = (state_q == REQ) && gate_open;
        rd_o               = req_o && (kind_q == OP_RD);
        prog_o             = req_o && (kind_q == OP_PROG);
        pg_erase_o         = req_o && (kind_q == OP_PG_ERASE);
        bk_erase_o         = req_o && (kind_q == OP_BK_ERASE);
        prog_fifo_rready_o = prog_o && prog_done_i && !error_i;
        req_addr_o         = addr_q[AW-1:WordW];
        req_word_o         = addr_q[WordW-1:0];
        req_bk_o           = addr_q[AW-1 -: BankW];
        addr_ovfl_o        = addr_q[AW];
        op_busy_o          = (state_q != IDLE);
        op_done_o          = (state_q == DONE);
        op_err_o           = (state_q == DONE) && err_q;
    end

endmodule
